mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 53 +++++
 rtl/mem_ldext.sv | 23 ++
 rtl/mem_access.sv | 169 ++++++++++++++++
 tb/tb_mem_access.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage byte-serial memory access unit:
// opcodes, funct3 codes, bus widths, FSM encoding and decode helpers.
package mem_access_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int OpBus      = 7;
  localparam int SubOpBus   = 3;
  localparam int ByteBus    = 8;

  localparam logic [OpBus-1:0] EXE_LB = 7'b0000011;
  localparam logic [OpBus-1:0] EXE_SB = 7'b0100011;

  localparam logic [SubOpBus-1:0] OP_LB  = 3'b000;
  localparam logic [SubOpBus-1:0] OP_LH  = 3'b001;
  localparam logic [SubOpBus-1:0] OP_LW  = 3'b010;
  localparam logic [SubOpBus-1:0] OP_LBU = 3'b100;
  localparam logic [SubOpBus-1:0] OP_LHU = 3'b101;
  localparam logic [SubOpBus-1:0] OP_SB  = 3'b000;
  localparam logic [SubOpBus-1:0] OP_SH  = 3'b001;
  localparam logic [SubOpBus-1:0] OP_SW  = 3'b010;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_DONE  = 2'd3
  } mem_state_e;

  function automatic logic [2:0] byte_count(input logic [SubOpBus-1:0] f3);
    case (f3[1:0])
      2'b00:   byte_count = 3'd1;
      2'b01:   byte_count = 3'd2;
      2'b10:   byte_count = 3'd4;
      default: byte_count = 3'd1;
    endcase
  endfunction

  function automatic logic is_valid_load(input logic [SubOpBus-1:0] f3);
    case (f3)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_valid_load = 1'b1;
      default:                             is_valid_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_valid_store(input logic [SubOpBus-1:0] f3);
    case (f3)
      OP_SB, OP_SH, OP_SW: is_valid_store = 1'b1;
      default:             is_valid_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_ldext.sv
// Load result formatter: selects and sign/zero-extends the assembled
// little-endian load buffer according to funct3.
module mem_ldext
  import mem_access_pkg::*;
(
  input  logic [SubOpBus-1:0] sub_aluop_i,
  input  logic [RegBus-1:0]   buf_i,
  output logic [RegBus-1:0]   ext_o
);

  // Width/sign selection of the load buffer
  always_comb begin
    case (sub_aluop_i)
      OP_LB:   ext_o = {{24{buf_i[7]}}, buf_i[7:0]};
      OP_LBU:  ext_o = {24'd0, buf_i[7:0]};
      OP_LH:   ext_o = {{16{buf_i[15]}}, buf_i[15:0]};
      OP_LHU:  ext_o = {16'd0, buf_i[15:0]};
      OP_LW:   ext_o = buf_i;
      default: ext_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: serialises loads/stores over an 8-bit RAM port, stalling the
// pipeline until the result is ready in the single DONE cycle.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic [OpBus-1:0]      aluop_i,
  input  logic [SubOpBus-1:0]   sub_aluop_i,
  input  logic [RegBus-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     reg2_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic [RegBus-1:0]     ram_addr_o,
  output logic [ByteBus-1:0]    ram_dout_o,
  output logic                  ram_we_o,
  input  logic [ByteBus-1:0]    ram_din_i,
  output logic                  mem_stall_o
);

  mem_state_e            state_r, state_nx_s;
  logic [2:0]            cnt_r, cnt_nx_s;
  logic [RegBus-1:0]     buf_r, buf_nx_s;

  logic                  is_load_s, is_store_s, ld_ok_s, st_ok_s;
  logic [2:0]            n_s;
  logic [1:0]            cnt_m1_s;
  logic [RegBus-1:0]     addr_sum_s, ext_s;

  logic [RegAddrBus-1:0] wd_s;
  logic                  wreg_s, we_s, stall_s;
  logic [RegBus-1:0]     wdata_s, addr_s;
  logic [ByteBus-1:0]    dout_s;

  assign is_load_s  = (aluop_i == EXE_LB);
  assign is_store_s = (aluop_i == EXE_SB);
  assign ld_ok_s    = is_load_s  && is_valid_load(sub_aluop_i);
  assign st_ok_s    = is_store_s && is_valid_store(sub_aluop_i);
  assign n_s        = byte_count(sub_aluop_i);
  assign cnt_m1_s   = cnt_r[1:0] - 2'd1;
  assign addr_sum_s = mem_addr_i + {29'd0, cnt_r};

  mem_ldext u_ldext (
    .sub_aluop_i (sub_aluop_i),
    .buf_i       (buf_r),
    .ext_o       (ext_s)
  );

  // State, byte counter and load buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= MEM_IDLE;
      cnt_r   <= 3'd0;
      buf_r   <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      buf_r   <= buf_nx_s;
    end
  end

  // Next-state logic and unmasked outputs
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    buf_nx_s   = buf_r;
    wd_s       = 5'd0;
    wreg_s     = 1'b0;
    wdata_s    = 32'd0;
    addr_s     = 32'd0;
    dout_s     = 8'd0;
    we_s       = 1'b0;
    stall_s    = 1'b0;
    case (state_r)
      MEM_IDLE: begin
        if (ld_ok_s) begin
          stall_s    = 1'b1;
          state_nx_s = MEM_LOAD;
          cnt_nx_s   = 3'd0;
          buf_nx_s   = 32'd0;
        end else if (st_ok_s) begin
          stall_s    = 1'b1;
          state_nx_s = MEM_STORE;
          cnt_nx_s   = 3'd0;
        end else if (is_load_s || is_store_s) begin
          // Malformed width: drop the access and return zero
          wd_s   = wd_i;
          wreg_s = wreg_i;
        end else begin
          wd_s    = wd_i;
          wreg_s  = wreg_i;
          wdata_s = wdata_i;
        end
      end
      MEM_LOAD: begin
        stall_s = 1'b1;
        if (cnt_r < n_s) begin
          addr_s = addr_sum_s;
        end else begin
          addr_s = 32'd0;
        end
        // RAM data lags its address by one cycle, so byte cnt-1 arrives now
        if (cnt_r != 3'd0) begin
          buf_nx_s[{cnt_m1_s, 3'b000} +: 8] = ram_din_i;
        end else begin
          buf_nx_s = buf_r;
        end
        if (cnt_r == n_s) begin
          state_nx_s = MEM_DONE;
          cnt_nx_s   = 3'd0;
        end else begin
          cnt_nx_s   = cnt_r + 3'd1;
        end
      end
      MEM_STORE: begin
        stall_s = 1'b1;
        addr_s  = addr_sum_s;
        dout_s  = reg2_i[{cnt_r[1:0], 3'b000} +: 8];
        we_s    = 1'b1;
        if (cnt_r == (n_s - 3'd1)) begin
          state_nx_s = MEM_DONE;
          cnt_nx_s   = 3'd0;
        end else begin
          cnt_nx_s   = cnt_r + 3'd1;
        end
      end
      MEM_DONE: begin
        wd_s       = wd_i;
        wreg_s     = wreg_i;
        state_nx_s = MEM_IDLE;
        if (is_load_s) begin
          wdata_s = ext_s;
        end else begin
          wdata_s = wdata_i;
        end
      end
      default: begin
        state_nx_s = MEM_IDLE;
        cnt_nx_s   = 3'd0;
      end
    endcase
  end

  // Reset forces every output low immediately, aborting any RAM write
  always_comb begin
    if (!rst) begin
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      ram_addr_o  = 32'd0;
      ram_dout_o  = 8'd0;
      ram_we_o    = 1'b0;
      mem_stall_o = 1'b0;
    end else begin
      wd_o        = wd_s;
      wreg_o      = wreg_s;
      wdata_o     = wdata_s;
      ram_addr_o  = addr_s;
      ram_dout_o  = dout_s;
      ram_we_o    = we_s;
      mem_stall_o = stall_s;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomised self-checking bench for mem_access with a byte RAM emulator
// and an instruction-level reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  wd_i = 5'd0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic [6:0]  aluop_i = 7'd0;
  logic [2:0]  sub_aluop_i = 3'd0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] reg2_i = 32'd0;
  logic [7:0]  ram_din_i = 8'd0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_dout_o;
  logic        ram_we_o;
  logic        mem_stall_o;

  localparam logic [6:0] OP_ADD = 7'b0110011;

  int checks = 0;
  int failures = 0;
  int writes = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .sub_aluop_i(sub_aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_we_o(ram_we_o),
    .ram_din_i(ram_din_i), .mem_stall_o(mem_stall_o)
  );

  logic [7:0] ram_mem   [logic [31:0]];
  logic [7:0] model_mem [logic [31:0]];

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rd_model(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a] = b;
    model_mem[a] = b;
  endtask

  // Byte RAM: registered read, synchronous write
  always @(posedge clk) begin
    ram_din_i <= rd_ram(ram_addr_o);
    if (ram_we_o) begin
      ram_mem[ram_addr_o] = ram_dout_o;
      writes = writes + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = {rd_model(a + 32'd3), rd_model(a + 32'd2), rd_model(a + 32'd1), rd_model(a)};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Expected-value slots filled by the driver each cycle
  bit          chk_en = 1'b0;
  bit          e_stall_c, e_addr_c, e_dout_c, e_we_c, e_wd_c, e_res_c, e_done;
  logic        e_stall, e_we, e_wreg;
  logic [31:0] e_addr, e_wdata;
  logic [7:0]  e_dout;
  logic [4:0]  e_wd;
  logic [31:0] done_wdata = 32'd0;
  int          stall_run = 0;
  int          done_stall = 0;

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en && rst) begin
      if (e_stall_c) chk("stall", {31'd0, mem_stall_o}, {31'd0, e_stall});
      if (e_addr_c)  chk("ram_addr", ram_addr_o, e_addr);
      if (e_dout_c)  chk("ram_dout", {24'd0, ram_dout_o}, {24'd0, e_dout});
      if (e_we_c)    chk("ram_we", {31'd0, ram_we_o}, {31'd0, e_we});
      if (e_wd_c)    chk("wd", {27'd0, wd_o}, {27'd0, e_wd});
      if (e_res_c) begin
        chk("wreg", {31'd0, wreg_o}, {31'd0, e_wreg});
        chk("wdata", wdata_o, e_wdata);
      end
      if (mem_stall_o) stall_run = stall_run + 1;
      if (e_done) begin
        done_wdata = wdata_o;
        done_stall = stall_run;
      end
    end
  end

  task automatic clear_exp();
    {e_stall_c, e_addr_c, e_dout_c, e_we_c, e_wd_c, e_res_c, e_done} = 7'd0;
    e_stall = 1'b0; e_we = 1'b0; e_wreg = 1'b0;
    e_addr = 32'd0; e_wdata = 32'd0; e_dout = 8'd0; e_wd = 5'd0;
  endtask

  task automatic exp_ram(input logic [31:0] a, input logic [7:0] d, input logic we,
                         input bit dc);
    e_addr_c = 1'b1; e_addr = a;
    e_dout_c = dc;   e_dout = d;
    e_we_c = 1'b1;   e_we = we;
  endtask

  task automatic exp_res(input bit wdc, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdat);
    e_wd_c = wdc; e_wd = wd;
    e_res_c = 1'b1; e_wreg = wreg; e_wdata = wdat;
  endtask

  task automatic zero_outputs_check(input string tag);
    chk({tag, "_wd"}, {27'd0, wd_o}, 32'd0);
    chk({tag, "_wreg"}, {31'd0, wreg_o}, 32'd0);
    chk({tag, "_wdata"}, wdata_o, 32'd0);
    chk({tag, "_addr"}, ram_addr_o, 32'd0);
    chk({tag, "_dout"}, {24'd0, ram_dout_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, ram_we_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, mem_stall_o}, 32'd0);
  endtask

  // Issues one instruction (called #1 after a rising edge) and holds it
  // for its full latency; abort_at >= 0 pulls reset mid-instruction.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] r2,
                           input logic [31:0] wdat, input logic [4:0] wd,
                           input logic wreg, input int abort_at);
    bit vld, vst, mem;
    int n, total, w0;
    logic [31:0] res;
    aluop_i = op; sub_aluop_i = f3; mem_addr_i = a; reg2_i = r2;
    wdata_i = wdat; wd_i = wd; wreg_i = wreg;
    mem = (op == EXE_LB) || (op == EXE_SB);
    vld = (op == EXE_LB) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    vst = (op == EXE_SB) && (f3 inside {3'b000, 3'b001, 3'b010});
    n = nbytes(f3);
    res = model_load(f3, a);
    total = vld ? n + 3 : (vst ? n + 2 : 1);
    stall_run = 0;
    for (int i = 0; i < total; i++) begin
      clear_exp();
      e_stall_c = 1'b1;
      if (vld || vst) begin
        e_stall = (i != total - 1);
        if (i == 0 || i == total - 1) exp_ram(32'd0, 8'd0, 1'b0, 1'b1);
        else if (vst) exp_ram(a + i - 1, r2[8*(i-1) +: 8], 1'b1, 1'b1);
        else if (i <= n) exp_ram(a + i - 1, 8'd0, 1'b0, 1'b0);
        else begin e_we_c = 1'b1; e_we = 1'b0; end
        if (i == total - 1) begin
          exp_res(1'b1, wd, wreg, vld ? res : wdat);
          e_done = 1'b1;
        end else if (i != 0) exp_res(1'b1, 5'd0, 1'b0, 32'd0);
      end else begin
        exp_ram(32'd0, 8'd0, 1'b0, 1'b1);
        exp_res(!mem, wd, wreg, mem ? 32'd0 : wdat);
        e_done = 1'b1;
      end
      chk_en = 1'b1;
      if (i == abort_at) begin
        #2;
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        zero_outputs_check("rst_abort");
        aluop_i = OP_ADD;
        w0 = writes;
        repeat (2) @(posedge clk);
        #1;
        chk("no_write_in_rst", writes, w0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("no_write_after_rst", writes, w0);
        chk("idle_after_rst_stall", {31'd0, mem_stall_o}, 32'd0);
        return;
      end
      @(posedge clk);
      #1;
      if (vst && i >= 1 && i <= n) model_mem[a + i - 1] = r2[8*(i-1) +: 8];
    end
    chk_en = 1'b0;
  endtask

  logic [2:0] ld_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] bad_ld [3] = '{3'b011, 3'b110, 3'b111};

  initial begin
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 128; i++) poke(i, 8'($urandom));

    // Reset with a pending load on the inputs: everything must read zero
    aluop_i = EXE_LB; sub_aluop_i = 3'b010; mem_addr_i = 32'h40;
    wdata_i = 32'hDEADBEEF; wd_i = 5'd7; wreg_i = 1'b1; reg2_i = 32'h11223344;
    #1;
    zero_outputs_check("reset");
    @(posedge clk);
    #1;
    zero_outputs_check("reset_edge");
    aluop_i = OP_ADD;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_instr(OP_ADD, 3'b000, 32'd0, 32'd0, 32'h00000123, 5'd5, 1'b1, -1);
    chk("add_lit", done_wdata, 32'h00000123);
    chk("add_stall_lit", done_stall, 32'd0);

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    run_instr(EXE_LB, 3'b010, 32'h100, 32'd0, 32'd0, 5'd3, 1'b1, -1);
    chk("lw_lit", done_wdata, 32'h12345678);
    chk("lw_stall_lit", done_stall, 32'd6);

    poke(32'h10, 8'h80);
    run_instr(EXE_LB, 3'b000, 32'h10, 32'd0, 32'd0, 5'd4, 1'b1, -1);
    chk("lb_lit", done_wdata, 32'hFFFFFF80);
    chk("lb_stall_lit", done_stall, 32'd3);
    run_instr(EXE_LB, 3'b100, 32'h10, 32'd0, 32'd0, 5'd4, 1'b1, -1);
    chk("lbu_lit", done_wdata, 32'h00000080);
    chk("lbu_stall_lit", done_stall, 32'd3);

    run_instr(EXE_SB, 3'b001, 32'h202, 32'hAABBCCDD, 32'h55, 5'd0, 1'b0, -1);
    chk("sh_byte0_lit", {24'd0, rd_ram(32'h202)}, 32'hDD);
    chk("sh_byte1_lit", {24'd0, rd_ram(32'h203)}, 32'hCC);
    chk("sh_stall_lit", done_stall, 32'd3);

    run_instr(EXE_SB, 3'b010, 32'hFFFFFFFE, 32'h01020304, 32'd0, 5'd0, 1'b0, -1);
    chk("sw_wrap_hi_lit", {24'd0, rd_ram(32'hFFFFFFFF)}, 32'h03);
    chk("sw_wrap_lo_lit", {24'd0, rd_ram(32'h00000001)}, 32'h01);
    chk("sw_stall_lit", done_stall, 32'd5);

    poke(32'h300, 8'h00); poke(32'h301, 8'h00);
    run_instr(EXE_SB, 3'b010, 32'h300, 32'h99887766, 32'd0, 5'd0, 1'b0, 2);
    chk("abort_byte0_kept", {24'd0, rd_ram(32'h300)}, 32'h66);
    chk("abort_byte1_unwritten", {24'd0, rd_ram(32'h301)}, 32'h00);
    run_instr(EXE_LB, 3'b010, 32'h300, 32'd0, 32'd0, 5'd9, 1'b1, -1);

    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 5) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                      : 32'($urandom_range(0, 127));
      case (kind)
        0, 1:    run_instr(7'($urandom_range(4, 31)) << 2, 3'($urandom), a, $urandom,
                           $urandom, 5'($urandom), 1'($urandom), -1);
        2, 3, 4: run_instr(EXE_LB, ld_f3[$urandom_range(0, 4)], a, $urandom,
                           $urandom, 5'($urandom), 1'($urandom), -1);
        5, 6, 7: run_instr(EXE_SB, 3'($urandom_range(0, 2)), a, $urandom,
                           $urandom, 5'($urandom), 1'($urandom), -1);
        8:       run_instr(EXE_LB, bad_ld[$urandom_range(0, 2)], a, $urandom,
                           $urandom, 5'($urandom), 1'($urandom), -1);
        default: run_instr(EXE_SB, 3'($urandom_range(3, 7)), a, $urandom,
                           $urandom, 5'($urandom), 1'($urandom), -1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
